fetch_queue: RTL

- Instruction fetch front end that sits directly upstream of the decoder and register-file read.
- Generates word fetch addresses and drives a request/acknowledge/response handshake to instruction memory.
- Buffers returned instructions, with their PCs, in a small FIFO and presents them to the core with valid/ready.
- Accepts branch redirects, flushes the FIFO and discards any in-flight response.

---
 rtl/fetch_queue.sv | 112 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues word fetches to instruction memory, buffers
// the returned instructions with their PCs in a small FIFO, and handles redirects.
module fetch_queue #(
  parameter int n     = 32,
  parameter int alen  = 6,
  parameter int depth = 2
) (
  input  logic            clock,
  input  logic            reset,
  output logic            mreq,
  output logic [alen-1:0] maddr,
  input  logic            mack,
  input  logic            mrvalid,
  input  logic [n-1:0]    mrdata,
  input  logic            redirect,
  input  logic [alen-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [n-1:0]    instr_out,
  output logic [alen-1:0] pc_out,
  input  logic            instr_ready
);

  localparam int pw = $clog2(depth);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  localparam logic [pw:0]     full_count = (pw+1)'(depth);
  localparam logic [pw:0]     cnt_one    = (pw+1)'(1);
  localparam logic [pw-1:0]   ptr_one    = pw'(1);
  localparam logic [alen-1:0] addr_one   = alen'(1);

  logic [1:0]        state;
  logic [alen-1:0]   fpc;
  logic [alen-1:0]   req_pc;
  logic [pw-1:0]     rd_ptr;
  logic [pw-1:0]     wr_ptr;
  logic [pw:0]       count;
  logic [n+alen-1:0] entries [depth];
  logic [n+alen-1:0] head;

  logic accept;
  logic enq;
  logic deq;

  // Gated by reset so no request is visible while reset is held; a redirect
  // in the same cycle suppresses the request combinationally.
  assign mreq        = reset && (state == FETCH) && (count < full_count) && !redirect;
  assign maddr       = fpc;
  assign accept      = mreq && mack;
  assign instr_valid = (count != '0);

  assign enq = (state == WAIT) && mrvalid && !redirect;
  assign deq = instr_valid && instr_ready && !redirect;

  assign head      = entries[rd_ptr];
  assign instr_out = head[n-1:0];
  assign pc_out    = head[n+alen-1:n];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= FETCH;
      fpc    <= '0;
      req_pc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      fpc    <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // An outstanding response not yet returned must be swallowed in DROP.
      case (state)
        WAIT, DROP: state <= mrvalid ? FETCH : DROP;
        default:    state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (accept) begin
            req_pc <= fpc;
            fpc    <= fpc + addr_one;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (mrvalid) state <= FETCH;
        end
        DROP: begin
          if (mrvalid) state <= FETCH;
        end
        default: state <= FETCH;
      endcase

      if (enq) wr_ptr <= wr_ptr + ptr_one;
      if (deq) rd_ptr <= rd_ptr + ptr_one;

      case ({enq, deq})
        2'b10:   count <= count + cnt_one;
        2'b01:   count <= count - cnt_one;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset && enq) entries[wr_ptr] <= {req_pc, mrdata};
  end

endmodule
